mux_n_reg: RTL
==============

// Module: mux_n_reg
// PURPOSE
//   Parametrised N-channel, WIDTH-bit selector with a one-entry registered output stage.
//   - Picks one of NCH input channels.
//   - Captures the chosen word into an output register.
//   - Presents it downstream with a valid/ready handshake.
//   Generalises the 2:1 4-bit enable-gated mux for datapath steering in the MIPS pipeline
//   (operand/writeback select) where a pipeline boundary and back-pressure are needed.
// PARAMETERS
//   WIDTH  4  data width per channel, >=1
//   NCH    2  number of input channels, >=2
//   SELW   $clog2(NCH)  localparam, select/channel-index width (not overridable)
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous reset, active-high
//   en         in   1          global enable; 0 blocks all captures
//   sel        in   SELW       channel select (ignored when MUX_RR_EN defined)
//   in_data    in   NCH*WIDTH  packed channels, ch i = in_data[i*WIDTH +: WIDTH]
//   in_valid   in   NCH        per-channel valid
//   in_ready   out  NCH        per-channel ready, combinational
//   out_data   out  WIDTH      registered data, forced 0 while out_valid=0
//   out_valid  out  1          output register holds a word
//   out_ready  in   1          downstream accepts
//   out_ch     out  SELW       channel index the held word came from
// BEHAVIOUR
//   - Reset (async, immediate): out_valid=0, out_data=0, out_ch=0, RR pointer=0.
//     Reset asserted mid-transfer discards the held word; no partial state survives.
//   - States: EMPTY (out_valid=0), FULL (out_valid=1).
//   - space = !out_valid | out_ready.
//   - grant g (fixed mode) = sel. Valid only if sel<NCH; sel>=NCH means no grant.
//   - in_ready[i] = en & space & granted & (i==g). At most one bit set; in_ready[i] is
//     independent of in_valid[i].
//   - capture = in_ready[g] & in_valid[g]. On capture at edge:
//     out_data <= ch g, out_ch <= g, out_valid <= 1. Latency 1 cycle input->output.
//   - FULL & out_ready & !capture: out_valid <= 0, out_data <= 0.
//   - FULL & out_ready & capture: simultaneous consume+load; new word replaces old,
//     out_valid stays 1. Full throughput: 1 word/cycle.
//   - FULL & !out_ready: hold out_data/out_ch stable, all in_ready=0.
//   - en=0: no capture; a held word still drains on out_ready (en does not gate output).
//   - sel change while FULL: no effect on held word; it affects only the next capture.
//   - Non-selected channels never see in_ready; their valids are ignored.
// CONFIGURATION
//   MUX_RR_EN undefined:
//     - fixed selection by sel as above.
//     - No pointer register is built.
//   MUX_RR_EN defined:
//     - sel ignored.
//     - SELW-bit pointer p. Grant g = first i in order p, p+1, ..., NCH-1, 0, ...
//       with in_valid[i]=1 (wrap-around). No valid channel means no grant.
//     - On capture p <= (g==NCH-1) ? 0 : g+1.
//     - p unchanged when no capture (en=0, stall, or no valid).
//     - Same handshake and latency as fixed mode.
// TESTING
//   1. Reset: rst=1 at any time -> out_valid=0, out_data=0, out_ch=0 within the same
//      cycle; release -> EMPTY.
//   2. WIDTH=4, NCH=2, en=1, sel=1, in_data={4'hA,4'h5}, both valid, out_ready=1
//      -> next edge out_data=4'hA, out_ch=1.
//      Then sel=0 -> next edge out_data=4'h5, out_ch=0.
//   3. Back-pressure: FULL with 4'hA, out_ready=0 for 3 cycles -> out_data stable 4'hA,
//      in_ready=0. Then out_ready=1 with valid on ch1=4'h3 -> 4'h3 loaded, out_valid
//      held 1 (no bubble).
//   4. en=0 with in_valid=2'b11 for 4 cycles -> no capture, in_ready=0. A held word
//      drains when out_ready=1 -> out_valid=0, out_data=0.
//   5. NCH=3, sel=2'd3 (out of range), all valid -> in_ready=0, no capture for
//      4 cycles.
//   6. MUX_RR_EN, NCH=4, all valid, out_ready=1 -> out_ch sequence 0,1,2,3,0.
//      With only ch2 valid -> 2,2,2.
//      With valids {1,3} and p=2 -> 3 then 1.

Source files
------------

// File: rtl/mux_n_reg.sv
// N-channel WIDTH-bit selector feeding a one-entry registered output stage with valid/ready.
// Define MUX_RR_EN to replace sel-based selection with a round-robin arbiter over in_valid.
module mux_n_reg #(
  parameter int WIDTH = 4,
  parameter int NCH   = 2,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [SELW-1:0]  grant_s;
  logic             granted_s;
  logic             space_s;
  logic [NCH-1:0]   in_ready_s;
  logic             capture_s;
  logic [WIDTH-1:0] grant_data_s;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic [SELW-1:0]  out_ch_r;

`ifdef MUX_RR_EN
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
  localparam logic [SELW-1:0] ONE_CH  = SELW'(1);

  logic [SELW-1:0] ptr_r;

  // Round-robin grant: first valid channel at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    grant_s   = '0;
    granted_s = 1'b0;
    idx       = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr_r) + k) % NCH;
      if (!granted_s && in_valid[idx]) begin
        granted_s = 1'b1;
        grant_s   = idx[SELW-1:0];
      end else begin
        granted_s = granted_s;
      end
    end
  end

  // Pointer moves just past the channel that was served; idle cycles leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (capture_s) begin
      ptr_r <= (grant_s == LAST_CH) ? '0 : grant_s + ONE_CH;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

  // Fixed grant from sel; an out-of-range select grants nobody.
  always_comb begin
    grant_s = sel;
    if ({1'b0, sel} < NCH_W) begin
      granted_s = 1'b1;
    end else begin
      granted_s = 1'b0;
    end
  end
`endif

  assign space_s = !out_valid_r || out_ready;

  // One-hot ready toward the granted channel, only when the stage can accept.
  always_comb begin
    in_ready_s = '0;
    if (en && space_s && granted_s) begin
      in_ready_s[grant_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  // Word of the granted channel; out-of-range grants read as zero and are never captured.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_s == SELW'(i)) begin
        grant_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  assign capture_s = |(in_ready_s & in_valid);

  // Output stage: load on capture, otherwise drain to zero when consumed, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= grant_data_s;
      out_ch_r    <= grant_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= out_ch_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_ch_r    <= out_ch_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_ch    = out_ch_r;

endmodule
